// File: rtl/level_decoding_ctrl_pkg.sv
// Shared definitions for the CAVLC level-decoding sequencer: phase encodings
// (shared with level_decoding), per-block-type coefficient limits and input helpers.
package level_decoding_ctrl_pkg;

    localparam int MAX_COEFF_LUMA4X4  = 16;
    localparam int MAX_COEFF_AC       = 15;
    localparam int MAX_COEFF_CHROMADC = 4;

    localparam int CAVLC_STATE_W = 4;

    // Encodings are fixed because the datapath decodes cavlc_decoder_state directly.
    typedef enum logic [CAVLC_STATE_W-1:0] {
        CAVLC_IDLE              = 4'd0,
        TRAILING_ONES_SIGN_FLAG = 4'd3,
        LEVEL_PREFIX            = 4'd4,
        LEVEL_SUFFIX            = 4'd5,
        LEVEL_DONE              = 4'd6
    } cavlc_state_e;

    typedef enum logic [1:0] {
        BITS_NONE,
        BITS_T1,
        BITS_PREFIX,
        BITS_SUFFIX
    } bits_sel_e;

    function automatic logic [4:0] clamp_total_coeff(input logic [4:0] tc, input int max_coeff);
        if (int'(tc) > max_coeff) begin
            return 5'(max_coeff);
        end
        return tc;
    endfunction

    // TrailingOnes is only 2 bits wide, so the ">3" case cannot be encoded.
    function automatic logic coeff_token_bad(input logic [4:0] tc, input logic [1:0] t1,
                                             input int max_coeff);
        return (int'(tc) > max_coeff) || ({3'b000, t1} > tc);
    endfunction

endpackage

// File: rtl/level_decoding_ctrl_if.sv
// Port bundle between the level-decoding sequencer and its datapath/bitstream buffer.
interface level_decoding_ctrl_if #(
    parameter int STATE_W = 4
);

    // Handshake: start is a one-cycle strobe, honoured only when the sequencer is idle
    // and not pulsing done. consume_valid is asserted only in a cycle where bs_ready is
    // high; bits_consumed is the advance for that cycle and reads 0 whenever
    // consume_valid is low. done and err are single-cycle pulses.
    logic               start;
    logic [4:0]         TotalCoeff;
    logic [1:0]         TrailingOnes;
    logic [3:0]         heading_one_pos;
    logic [3:0]         levelSuffixSize;
    logic               bs_ready;
    logic [STATE_W-1:0] cavlc_decoder_state;
    logic [3:0]         i_level;
    logic [4:0]         bits_consumed;
    logic               consume_valid;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, TotalCoeff, TrailingOnes, heading_one_pos, levelSuffixSize, bs_ready,
        input  cavlc_decoder_state, i_level, bits_consumed, consume_valid, busy, done, err
    );

    modport slave (
        input  start, TotalCoeff, TrailingOnes, heading_one_pos, levelSuffixSize, bs_ready,
        output cavlc_decoder_state, i_level, bits_consumed, consume_valid, busy, done, err
    );

endinterface

// File: rtl/level_decoding_ctrl_bits_mux.sv
// Selects how many bitstream bits the current level-decoding phase consumes.
import level_decoding_ctrl_pkg::*;

module level_bits_mux (
    input  bits_sel_e  sel,
    input  logic [1:0] t1,
    input  logic [3:0] prefix_zeros,
    input  logic [3:0] suffix_size,
    output logic [4:0] bits
);

    always_comb begin
        bits = 5'd0;
        case (sel)
            BITS_T1:     bits = {3'b000, t1};
            // level_prefix is the leading zeros plus the terminating one bit.
            BITS_PREFIX: bits = {1'b0, prefix_zeros} + 5'd1;
            BITS_SUFFIX: bits = {1'b0, suffix_size};
            default:     bits = 5'd0;
        endcase
    end

endmodule

// File: rtl/level_decoding_ctrl.sv
// CAVLC level-decoding sequencer: walks trailing-ones signs, level prefixes and suffixes.
// Build option: LEVEL_CTRL_RANGE_CHECK_EN rejects out-of-range coeff_token values with err.
import level_decoding_ctrl_pkg::*;

module level_decoding_ctrl #(
    parameter int MAX_COEFF = MAX_COEFF_LUMA4X4,
    parameter int STATE_W   = CAVLC_STATE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    level_decoding_ctrl_if.slave bus
);

    cavlc_state_e state_q;
    cavlc_state_e state_d;

    logic [4:0] tc_r;
    logic [1:0] t1_r;
    logic [3:0] i_level_q;
    logic       done_q;
    logic [4:0] tc_in;
    logic [4:0] next_count;
    logic       start_ok;
    logic       range_err;
    logic       consume_valid;
    bits_sel_e  bits_sel;

    // The done cycle still counts as busy for start, so a back-to-back start is dropped.
    assign start_ok   = bus.start && (state_q == CAVLC_IDLE) && !done_q;
    assign tc_in      = clamp_total_coeff(bus.TotalCoeff, MAX_COEFF);
    assign next_count = {1'b0, i_level_q} + 5'd1;

`ifdef LEVEL_CTRL_RANGE_CHECK_EN
    logic err_q;

    assign range_err = coeff_token_bad(bus.TotalCoeff, bus.TrailingOnes, MAX_COEFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= start_ok && range_err;
        end
    end

    assign bus.err = err_q;
`else
    assign range_err = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CAVLC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CAVLC_IDLE: begin
                if (start_ok) begin
                    if (range_err || (tc_in == 5'd0)) begin
                        state_d = LEVEL_DONE;
                    end else if (bus.TrailingOnes != 2'd0) begin
                        state_d = TRAILING_ONES_SIGN_FLAG;
                    end else begin
                        state_d = LEVEL_PREFIX;
                    end
                end
            end
            TRAILING_ONES_SIGN_FLAG: begin
                if (bus.bs_ready) begin
                    state_d = (tc_r <= {3'b000, t1_r}) ? LEVEL_DONE : LEVEL_PREFIX;
                end
            end
            LEVEL_PREFIX: begin
                if (bus.bs_ready) begin
                    state_d = LEVEL_SUFFIX;
                end
            end
            LEVEL_SUFFIX: begin
                // >= rather than == so an untrusted TrailingOnes > TotalCoeff still terminates.
                if (bus.bs_ready) begin
                    state_d = (next_count >= tc_r) ? LEVEL_DONE : LEVEL_PREFIX;
                end
            end
            LEVEL_DONE: state_d = CAVLC_IDLE;
            default:    state_d = CAVLC_IDLE;
        endcase
    end

    always_comb begin
        consume_valid = 1'b0;
        bits_sel      = BITS_NONE;
        case (state_q)
            TRAILING_ONES_SIGN_FLAG: begin
                consume_valid = bus.bs_ready;
                bits_sel      = bus.bs_ready ? BITS_T1 : BITS_NONE;
            end
            LEVEL_PREFIX: begin
                consume_valid = bus.bs_ready;
                bits_sel      = bus.bs_ready ? BITS_PREFIX : BITS_NONE;
            end
            LEVEL_SUFFIX: begin
                consume_valid = bus.bs_ready;
                bits_sel      = bus.bs_ready ? BITS_SUFFIX : BITS_NONE;
            end
            default: begin
                consume_valid = 1'b0;
                bits_sel      = BITS_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_r      <= 5'd0;
            t1_r      <= 2'd0;
            i_level_q <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == LEVEL_DONE);
            if (start_ok && !range_err) begin
                tc_r <= tc_in;
                t1_r <= bus.TrailingOnes;
            end
            case (state_q)
                TRAILING_ONES_SIGN_FLAG: begin
                    if (bus.bs_ready) begin
                        i_level_q <= {2'b00, t1_r};
                    end
                end
                LEVEL_SUFFIX: begin
                    // Saturate: a 16-level block finishes on the write at index 15.
                    if (bus.bs_ready && (i_level_q != 4'hF)) begin
                        i_level_q <= i_level_q + 4'd1;
                    end
                end
                LEVEL_DONE: i_level_q <= 4'd0;
                default: ;
            endcase
        end
    end

    level_bits_mux u_bits_mux (
        .sel          (bits_sel),
        .t1           (t1_r),
        .prefix_zeros (bus.heading_one_pos),
        .suffix_size  (bus.levelSuffixSize),
        .bits         (bus.bits_consumed)
    );

    assign bus.cavlc_decoder_state = STATE_W'(state_q);
    assign bus.i_level             = i_level_q;
    assign bus.consume_valid       = consume_valid;
    assign bus.busy                = (state_q != CAVLC_IDLE);
    assign bus.done                = done_q;

endmodule

// File: tb/tb_level_decoding_ctrl.sv
// Bench for level_decoding_ctrl: directed coeff_token cases plus randomized decodes
// checked every cycle against a consume-sequence model of a residual block.
module tb_level_decoding_ctrl;

  localparam int MAX_COEFF = 16;
  localparam int STATE_W   = 4;
  localparam int INT_MAX   = 32'h7fff_ffff;
  localparam logic [1:0] K_T1  = 2'd1;
  localparam logic [1:0] K_PRE = 2'd2;
  localparam logic [1:0] K_SUF = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  level_decoding_ctrl_if #(.STATE_W(STATE_W)) bus ();

  level_decoding_ctrl #(.MAX_COEFF(MAX_COEFF), .STATE_W(STATE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- per-cycle input driver ----------------
  logic       rdy_rand  = 1'b0;
  logic       rdy_level = 1'b1;
  logic       fix_en    = 1'b0;
  logic [3:0] fix_hop   = 4'd0;
  logic [3:0] fix_lss   = 4'd0;

  always @(posedge clk) begin
    #2;
    bus.heading_one_pos = fix_en ? fix_hop : 4'($urandom_range(0, 15));
    bus.levelSuffixSize = fix_en ? fix_lss : 4'($urandom_range(0, 15));
    bus.bs_ready        = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_level;
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [1:0] exp_q[$];
  logic       m_active   = 1'b0;
  int         done_at    = -1;
  int         err_at     = -1;
  logic [3:0] m_ilvl     = 4'd0;
  logic [1:0] m_t1       = 2'd0;
  int         last_start = 0;
  int         last_done  = 0;
  int         n_pulse    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : model
    logic [1:0] head;
    logic [3:0] exp_state;
    logic       exp_cv;
    logic [4:0] exp_bits;
    int         tc;
    int         t1;
    logic       bad;
    if (cyc >= 1) begin
      exp_cv   = 1'b0;
      exp_bits = 5'd0;
      if (m_active && exp_q.size() > 0) begin
        head      = exp_q[0];
        exp_state = (head == K_T1) ? 4'd3 : (head == K_PRE) ? 4'd4 : 4'd5;
        check("state_phase", bus.cavlc_decoder_state, exp_state);
        check("i_level_phase", bus.i_level, m_ilvl);
        if (bus.bs_ready) begin
          exp_cv   = 1'b1;
          exp_bits = (head == K_T1)  ? {3'b000, m_t1} :
                     (head == K_PRE) ? {1'b0, bus.heading_one_pos} + 5'd1 :
                                       {1'b0, bus.levelSuffixSize};
          void'(exp_q.pop_front());
          if (head == K_T1) m_ilvl = {2'b00, m_t1};
          else if (head == K_SUF && m_ilvl != 4'd15) m_ilvl = m_ilvl + 4'd1;
          if (exp_q.size() == 0) done_at = cyc + 2;
        end
      end else if (m_active && cyc == done_at - 1) begin
        check("state_done", bus.cavlc_decoder_state, 6);
        check("i_level_done", bus.i_level, m_ilvl);
      end else begin
        check("state_idle", bus.cavlc_decoder_state, 0);
        check("i_level_idle", bus.i_level, 0);
      end
      check("consume_valid", bus.consume_valid, exp_cv);
      check("bits_consumed", bus.bits_consumed, exp_bits);
      check("busy", bus.busy, m_active && cyc < done_at);
      check("done", bus.done, m_active && cyc == done_at);
      check("err", bus.err, cyc == err_at);
      if (bus.consume_valid) n_pulse++;
      if (bus.done) last_done = cyc;

      if (!reset && bus.start && !m_active) begin
        tc  = int'(bus.TotalCoeff);
        t1  = int'(bus.TrailingOnes);
        bad = 1'b0;
`ifdef LEVEL_CTRL_RANGE_CHECK_EN
        bad = (tc > MAX_COEFF) || (t1 > tc);
`endif
        m_active   = 1'b1;
        last_start = cyc;
        n_pulse    = 0;
        m_ilvl     = 4'd0;
        m_t1       = 2'(t1);
        done_at    = INT_MAX;
        exp_q.delete();
        if (bad) begin
          err_at  = cyc + 1;
          done_at = cyc + 2;
        end else begin
          if (tc > MAX_COEFF) tc = MAX_COEFF;
          if (tc == 0) begin
            done_at = cyc + 2;
          end else begin
            if (t1 > 0) exp_q.push_back(K_T1);
            for (int j = t1; j < tc; j++) begin
              exp_q.push_back(K_PRE);
              exp_q.push_back(K_SUF);
            end
          end
        end
      end else if (m_active && cyc == done_at) begin
        m_active = 1'b0;
      end
      if (reset) begin
        m_active = 1'b0;
        exp_q.delete();
        err_at   = -1;
        done_at  = -1;
        m_ilvl   = 4'd0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [4:0] tc, input logic [1:0] t1);
    bus.TotalCoeff   = tc;
    bus.TrailingOnes = t1;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.TotalCoeff   = 5'($urandom_range(0, 31));
    bus.TrailingOnes = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (m_active && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (m_active) begin
      check("decode_timeout", m_active, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
  endtask

  task automatic run_case(input logic [4:0] tc, input logic [1:0] t1,
                          input int exp_lat, input int exp_pulses);
    pulse_start(tc, t1);
    wait_idle(300);
    check("latency", last_done - last_start, exp_lat);
    check("n_consume", n_pulse, exp_pulses);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tc;
    int t1;
    bus.start        = 1'b0;
    bus.TotalCoeff   = 5'd0;
    bus.TrailingOnes = 2'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_case(5'd0, 2'd0, 2, 0);
    run_case(5'd3, 2'd3, 3, 1);

    fix_en  = 1'b1;
    fix_hop = 4'd2;
    fix_lss = 4'd1;
    run_case(5'd5, 2'd1, 11, 9);

    pulse_start(5'd5, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    rdy_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rdy_level = 1'b1;
    wait_idle(300);
    check("latency_stall", last_done - last_start, 14);
    check("n_consume_stall", n_pulse, 9);
    fix_en = 1'b0;

    run_case(5'd16, 2'd0, 34, 32);

    // Reset in the middle of a 16-level block, while level 7 is being decoded.
    pulse_start(5'd16, 2'd0);
    for (int n = 0; n < 100 && m_ilvl != 4'd7; n++) begin
      @(posedge clk);
      #1;
    end
    check("reached_level7", m_ilvl, 7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    repeat (40) @(posedge clk);
    #1;

`ifdef LEVEL_CTRL_RANGE_CHECK_EN
    run_case(5'd20, 2'd2, 2, 0);
    run_case(5'd1, 2'd3, 2, 0);
`else
    run_case(5'd20, 2'd2, 31, 29);
`endif

    // start during the done pulse must be dropped.
    pulse_start(5'd0, 2'd0);
    @(posedge clk);
    #1;
    bus.TotalCoeff   = 5'd3;
    bus.TrailingOnes = 2'd3;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("start_in_done_ignored", n_pulse, 0);

    // reset wins over a simultaneous start.
    reset            = 1'b1;
    bus.TotalCoeff   = 5'd5;
    bus.TrailingOnes = 2'd0;
    bus.start        = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_beats_start", bus.busy, 0);

    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) tc = $urandom_range(17, 31);
      else tc = $urandom_range(0, 16);
      t1 = $urandom_range(0, (tc < 3) ? tc : 3);
`ifdef LEVEL_CTRL_RANGE_CHECK_EN
      if ($urandom_range(0, 9) == 0) begin
        tc = $urandom_range(0, 2);
        t1 = 3;
      end
`endif
      pulse_start(5'(tc), 2'(t1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        bus.TotalCoeff   = 5'($urandom_range(0, 16));
        bus.TrailingOnes = 2'($urandom_range(0, 3));
        if (bus.TrailingOnes > bus.TotalCoeff[1:0] && bus.TotalCoeff < 5'd3)
          bus.TrailingOnes = bus.TotalCoeff[1:0];
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
      wait_idle(600);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
